// File: rtl/vector_wb_arbiter.sv
// Arbitrates the vector register-file write port between ALU results and load returns.
// One source owns the port for a whole BEATS-beat register write; bursts alternate round-robin.
module vector_wb_arbiter #(
  parameter int REGISTER_NUMBERS = 32,
  parameter int DATA_WIDTH       = 256,
  parameter int BEATS            = 4,
  localparam int RW              = $clog2(REGISTER_NUMBERS),
  localparam int BW              = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RW-1:0]         alu_wb_dest,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [RW-1:0]         mem_wb_dest,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  rf_we,
  output logic [RW-1:0]         rf_addr,
  output logic [BW-1:0]         rf_beat,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  operation_done,
  output logic [RW-1:0]         alu_dest,
  output logic                  read_done,
  output logic [RW-1:0]         mem_dest
);

  typedef enum logic [1:0] {IDLE, ALU_BURST, MEM_BURST} state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t          state;
  logic [BW-1:0]   cnt;
  logic [RW-1:0]   lock_dest;
  logic            last_grant;

  logic            alu_acc;
  logic            mem_acc;
  logic            acc;
  logic            in_idle;
  logic            last_beat;
  logic [RW-1:0]   wr_dest;
  logic [BW-1:0]   wr_beat;
  logic [DATA_WIDTH-1:0] wr_data;

  // In IDLE the grant depends on who is asking; inside a burst only the owner is ever ready.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE: begin
        alu_ready = alu_valid & (~mem_valid | last_grant);
        mem_ready = mem_valid & (~alu_valid | ~last_grant);
      end
      ALU_BURST: alu_ready = 1'b1;
      MEM_BURST: mem_ready = 1'b1;
      default: begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
      end
    endcase
  end

  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;
  assign acc       = alu_acc | mem_acc;
  assign in_idle   = (state == IDLE);
  assign wr_dest   = in_idle ? (mem_acc ? mem_wb_dest : alu_wb_dest) : lock_dest;
  assign wr_beat   = in_idle ? '0 : cnt;
  assign wr_data   = mem_acc ? mem_wb_data : alu_wb_data;
  assign last_beat = in_idle ? (BEATS == 1) : (cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lock_dest      <= '0;
      last_grant     <= 1'b1;
      rf_we          <= 1'b0;
      rf_addr        <= '0;
      rf_beat        <= '0;
      rf_wdata       <= '0;
      operation_done <= 1'b0;
      alu_dest       <= '0;
      read_done      <= 1'b0;
      mem_dest       <= '0;
    end else begin
      rf_we          <= acc;
      operation_done <= alu_acc & last_beat;
      read_done      <= mem_acc & last_beat;
      if (acc) begin
        rf_addr  <= wr_dest;
        rf_beat  <= wr_beat;
        rf_wdata <= wr_data;
      end
      if (alu_acc & last_beat) alu_dest <= wr_dest;
      if (mem_acc & last_beat) mem_dest <= wr_dest;

      case (state)
        IDLE: begin
          if (acc) begin
            lock_dest  <= wr_dest;
            last_grant <= mem_acc;
            if (!last_beat) begin
              state <= mem_acc ? MEM_BURST : ALU_BURST;
              cnt   <= BW'(1);
            end
          end
        end
        ALU_BURST, MEM_BURST: begin
          // A missing valid simply stalls; ownership is kept until the final beat.
          if (acc) begin
            if (last_beat) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Directed bench: multi-beat arbiter (BEATS=4) plus a single-beat instance (BEATS=1).
module tb_vector_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // BEATS=4 instance
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_wb_dest, mem_wb_dest;
  logic [31:0] alu_wb_data, mem_wb_data;
  logic        rf_we, operation_done, read_done;
  logic [4:0]  rf_addr, alu_dest, mem_dest;
  logic [1:0]  rf_beat;
  logic [31:0] rf_wdata;

  // BEATS=1 instance
  logic        rst1;
  logic        a1_valid, a1_ready, m1_valid, m1_ready;
  logic [4:0]  a1_dest_in, m1_dest_in;
  logic [31:0] a1_data, m1_data;
  logic        r1_we, od1, rd1;
  logic [4:0]  r1_addr, a1_dest, m1_dest;
  logic [0:0]  r1_beat;
  logic [31:0] r1_wdata;

  vector_wb_arbiter #(.REGISTER_NUMBERS(32), .DATA_WIDTH(32), .BEATS(4)) u_dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wb_dest(alu_wb_dest), .alu_wb_data(alu_wb_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wb_dest(mem_wb_dest), .mem_wb_data(mem_wb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_beat(rf_beat), .rf_wdata(rf_wdata),
    .operation_done(operation_done), .alu_dest(alu_dest),
    .read_done(read_done), .mem_dest(mem_dest)
  );

  vector_wb_arbiter #(.REGISTER_NUMBERS(32), .DATA_WIDTH(32), .BEATS(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .alu_valid(a1_valid), .alu_ready(a1_ready), .alu_wb_dest(a1_dest_in), .alu_wb_data(a1_data),
    .mem_valid(m1_valid), .mem_ready(m1_ready), .mem_wb_dest(m1_dest_in), .mem_wb_data(m1_data),
    .rf_we(r1_we), .rf_addr(r1_addr), .rf_beat(r1_beat), .rf_wdata(r1_wdata),
    .operation_done(od1), .alu_dest(a1_dest),
    .read_done(rd1), .mem_dest(m1_dest)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks ready before the edge and the registered port after it.
  task automatic cyc(input string tag,
                     input logic av, input logic [4:0] ad, input logic [31:0] adat,
                     input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                     input logic ear, input logic emr,
                     input logic ewe, input logic [4:0] eaddr, input logic [1:0] ebeat,
                     input logic [31:0] edat, input logic eod, input logic erd);
    alu_valid = av; alu_wb_dest = ad; alu_wb_data = adat;
    mem_valid = mv; mem_wb_dest = md; mem_wb_data = mdat;
    #1;
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(ear));
    chk({tag, ".mem_ready"}, 64'(mem_ready), 64'(emr));
    @(posedge clk); #1;
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(ewe));
    if (ewe) begin
      chk({tag, ".rf_addr"}, 64'(rf_addr), 64'(eaddr));
      chk({tag, ".rf_beat"}, 64'(rf_beat), 64'(ebeat));
      chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(edat));
    end
    chk({tag, ".operation_done"}, 64'(operation_done), 64'(eod));
    chk({tag, ".read_done"}, 64'(read_done), 64'(erd));
    if (eod) chk({tag, ".alu_dest"}, 64'(alu_dest), 64'(eaddr));
    if (erd) chk({tag, ".mem_dest"}, 64'(mem_dest), 64'(eaddr));
    $display("cyc %s av=%0b mv=%0b we=%0b addr=%0d beat=%0d od=%0b rd=%0b",
             tag, av, mv, rf_we, rf_addr, rf_beat, operation_done, read_done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset.rf_we", 64'(rf_we), 64'd0);
    chk("reset.rf_addr", 64'(rf_addr), 64'd0);
    chk("reset.rf_wdata", 64'(rf_wdata), 64'd0);
    chk("reset.operation_done", 64'(operation_done), 64'd0);
    chk("reset.alu_dest", 64'(alu_dest), 64'd0);
    chk("reset.mem_dest", 64'(mem_dest), 64'd0);
    @(posedge clk); #1;
  endtask

  int k;
  logic own_alu;
  logic [31:0] ad, md;

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    alu_valid = 0; mem_valid = 0; alu_wb_dest = 0; mem_wb_dest = 0; alu_wb_data = 0; mem_wb_data = 0;
    a1_valid = 0; m1_valid = 0; a1_dest_in = 0; m1_dest_in = 0; a1_data = 0; m1_data = 0;
    k = 0;
    do_reset();

    // ALU-only burst to r5; dest input changes after beat 0 must be ignored
    for (int i = 0; i < 4; i++) begin
      ad = 32'hD000_0000 + i;
      cyc($sformatf("alu_only.b%0d", i), 1, (i == 0) ? 5'd5 : 5'd13, ad, 0, 5'd0, 32'h0,
          1, 0, 1, 5'd5, 2'(i), ad, i == 3, 0);
    end
    cyc("alu_only.idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 2'd0, 32'h0, 0, 0);

    // Back-to-back ALU bursts r1 then r2: eight consecutive writes
    for (int i = 0; i < 8; i++) begin
      ad = 32'hC000_0000 + i;
      cyc($sformatf("b2b.b%0d", i), 1, (i == 0) ? 5'd1 : ((i == 4) ? 5'd2 : 5'd15), ad, 0, 5'd0, 32'h0,
          1, 0, 1, (i < 4) ? 5'd1 : 5'd2, 2'(i % 4), ad, (i % 4) == 3, 0);
    end

    // Both sources valid from reset: ALU, MEM, ALU bursts
    do_reset();
    for (int b = 0; b < 3; b++) begin
      own_alu = (b != 1);
      for (int i = 0; i < 4; i++) begin
        ad = 32'hA000_0000 + k; md = 32'hB000_0000 + k; k++;
        cyc($sformatf("rr.burst%0d.b%0d", b, i), 1, 5'd3, ad, 1, 5'd7, md,
            own_alu, !own_alu, 1, own_alu ? 5'd3 : 5'd7, 2'(i), own_alu ? ad : md,
            own_alu && i == 3, !own_alu && i == 3);
      end
    end

    // MEM burst to r6 with a two-cycle stall and a dest change; ALU stays locked out
    cyc("mstall.b0", 1, 5'd3, 32'h11, 1, 5'd6, 32'h20, 0, 1, 1, 5'd6, 2'd0, 32'h20, 0, 0);
    cyc("mstall.b1", 1, 5'd3, 32'h12, 1, 5'd9, 32'h21, 0, 1, 1, 5'd6, 2'd1, 32'h21, 0, 0);
    cyc("mstall.s0", 1, 5'd3, 32'h13, 0, 5'd9, 32'h22, 0, 1, 0, 5'd0, 2'd0, 32'h0, 0, 0);
    cyc("mstall.s1", 1, 5'd3, 32'h14, 0, 5'd9, 32'h23, 0, 1, 0, 5'd0, 2'd0, 32'h0, 0, 0);
    cyc("mstall.b2", 1, 5'd3, 32'h15, 1, 5'd9, 32'h24, 0, 1, 1, 5'd6, 2'd2, 32'h24, 0, 0);
    cyc("mstall.b3", 1, 5'd3, 32'h16, 1, 5'd9, 32'h25, 0, 1, 1, 5'd6, 2'd3, 32'h25, 0, 1);

    // ALU burst to r11 cut by reset after beat 2
    for (int i = 0; i < 3; i++) begin
      ad = 32'hE000_0000 + i;
      cyc($sformatf("rstmid.b%0d", i), 1, 5'd11, ad, 0, 5'd0, 32'h0, 1, 0, 1, 5'd11, 2'(i), ad, 0, 0);
    end
    rst = 1'b1;
    #1;
    chk("rstmid.rf_we", 64'(rf_we), 64'd0);
    chk("rstmid.rf_addr", 64'(rf_addr), 64'd0);
    chk("rstmid.rf_beat", 64'(rf_beat), 64'd0);
    chk("rstmid.rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rstmid.operation_done", 64'(operation_done), 64'd0);
    chk("rstmid.read_done", 64'(read_done), 64'd0);
    chk("rstmid.alu_dest", 64'(alu_dest), 64'd0);
    chk("rstmid.mem_dest", 64'(mem_dest), 64'd6 & 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("rstmid.idle", 0, 5'd11, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 2'd0, 32'h0, 0, 0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("rstmid.tie.alu_ready", 64'(alu_ready), 64'd1);
    chk("rstmid.tie.mem_ready", 64'(mem_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      md = 32'hF000_0000 + i;
      cyc($sformatf("rstmid.mem.b%0d", i), 0, 5'd0, 32'h0, 1, 5'd4, md, 0, 1, 1, 5'd4, 2'(i), md, 0, i == 3);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // BEATS=1: grants alternate every cycle, one done pulse per write
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      own_alu = (j % 2 == 0);
      a1_valid = 1; a1_dest_in = 5'd8; a1_data = 32'h5000_0000 + j;
      m1_valid = 1; m1_dest_in = 5'd9; m1_data = 32'h6000_0000 + j;
      #1;
      chk($sformatf("b1.c%0d.alu_ready", j), 64'(a1_ready), 64'(own_alu));
      chk($sformatf("b1.c%0d.mem_ready", j), 64'(m1_ready), 64'(!own_alu));
      @(posedge clk); #1;
      chk($sformatf("b1.c%0d.rf_we", j), 64'(r1_we), 64'd1);
      chk($sformatf("b1.c%0d.rf_addr", j), 64'(r1_addr), own_alu ? 64'd8 : 64'd9);
      chk($sformatf("b1.c%0d.rf_beat", j), 64'(r1_beat), 64'd0);
      chk($sformatf("b1.c%0d.rf_wdata", j), 64'(r1_wdata),
          own_alu ? 64'(32'h5000_0000 + j) : 64'(32'h6000_0000 + j));
      chk($sformatf("b1.c%0d.operation_done", j), 64'(od1), 64'(own_alu));
      chk($sformatf("b1.c%0d.read_done", j), 64'(rd1), 64'(!own_alu));
      if (own_alu) chk($sformatf("b1.c%0d.alu_dest", j), 64'(a1_dest), 64'd8);
      else         chk($sformatf("b1.c%0d.mem_dest", j), 64'(m1_dest), 64'd9);
      $display("b1 cyc %0d we=%0b addr=%0d od=%0b rd=%0b", j, r1_we, r1_addr, od1, rd1);
    end
    a1_valid = 0; m1_valid = 0;
    @(posedge clk); #1;
    chk("b1.idle.rf_we", 64'(r1_we), 64'd0);
    chk("b1.idle.read_done", 64'(rd1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
